serial_byte_tx: RTL and testbench
=================================

# serial_byte_tx

Serial byte transmitter that sits directly upstream of the serial-data receiver FSM and drives its `din` line. It accepts bytes over a valid/ready handshake and emits one frame per byte at one bit per clock: start bit (0), 8 data bits LSB first, an optional parity bit, and one or two stop bits (1). The line idles at 1, so the receiver sees a legal idle between frames.

## Interface
Parameters:
- `PARITY`, default 0: 0 = no parity bit; 1 = even parity (bit = XOR of data bits); 2 = odd parity (bit = inverted XOR).
- `STOP_BITS`, default 1: number of stop-bit cycles, 1 or 2. Other values are illegal.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a byte on `in_byte`.
- `in_ready`  out  1  transmitter can accept a byte this cycle.
- `in_byte`  in  8  byte to transmit; sampled only on an accepted transfer.
- `dout`  out  1  serial line to the receiver; registered output.
- `busy`  out  1  a frame is in progress (start, data, parity or stop).

## Operation
- A transfer occurs on a rising edge where `in_valid && in_ready`. `in_byte` is latched into an 8-bit shift register, and parity is computed from the latched value.
- States:
  - IDLE: `dout`=1.
  - START: 1 cycle, `dout`=0.
  - DATA: 8 cycles, `dout`=shift[0], shifting right each cycle, with a 3-bit counter 0..7.
  - PARITY: 1 cycle, present only if `PARITY`≠0.
  - STOP: `STOP_BITS` cycles, `dout`=1.
- State transitions:
  - IDLE to START on transfer.
  - START to DATA.
  - DATA to PARITY (or STOP) after bit 7.
  - PARITY to STOP.
  - From the last STOP cycle: to START if a transfer occurs in that cycle, otherwise to IDLE.
- `in_ready` is combinational: 1 in IDLE, and 1 in the last STOP cycle. It is 0 everywhere else.
- `busy` is 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- `in_valid` held while `in_ready`=0 has no effect. The producer holds the byte until it is accepted.
- Reset (async, `reset`=0): state goes to IDLE, `dout`=1, `busy`=0, and the counter and shift register clear.
  - Reset mid-frame aborts the frame immediately; the line returns to 1 with no stop-bit completion.
  - While `reset`=0, no transfer is accepted even though the state is IDLE.

## Timing
- Latency: a transfer at edge N puts the start bit on `dout` during cycle N+1 (after edge N). Data bit k appears in cycle N+2+k.
- Then, per configuration:
  - No parity: the stop bit is in cycle N+10, giving a frame length of 9+`PARITY?1:0`+`STOP_BITS` cycles.
  - With parity: the parity bit is in cycle N+10 and the stop bit in N+11.
- Back-to-back: accepting in the last stop cycle makes the next start bit follow with zero idle cycles. The sustained rate is one byte per frame length.
- A gap of at least 1 idle cycle occurs only when `in_valid` is low in the last stop cycle.
- `busy` rises in the cycle after the transfer edge. It falls in the cycle after the last stop cycle unless a new frame begins there.
- `dout` is glitch-free, driven directly from a flop.

## Test plan
- **Reset and idle:** assert `reset`=0 with `in_valid`=1 for 3 cycles → `dout`=1, `busy`=0, no frame starts. Release reset and hold `in_valid`=0 for 20 cycles → `dout` stays 1.
- **Single byte, defaults:** send 0xA5 → `dout` from cycle N+1 is 0,1,0,1,0,0,1,0,1,1, then idle 1. `in_ready`=0 from N+1 through N+9, except it is 1 in N+10. The receiver model reports done with out_byte=0xA5.
- **Back-to-back, defaults:** hold `in_valid` with bytes 0x00 then 0xFF → 20 contiguous cycles 0,00000000,1,0,11111111,1 with no idle gap. The second accept occurs in the first frame's stop cycle.
- **Parity:**
  - `PARITY`=1, send 0x07 → parity bit 1.
  - `PARITY`=2, send 0x07 → parity bit 0.
  - In both cases the frame is 11 cycles and the stop bit is in N+11.
- **Two stop bits:** `STOP_BITS`=2, back-to-back 0x3C, 0xC3 → two 1-cycle stop bits between frames. `in_ready` is high only in the second stop cycle, giving a period of 11 cycles.
- **Reset mid-frame:** send 0x55, then assert `reset` during data bit 3 → `dout`=1 and `busy`=0 immediately. After release, send 0x81 → a clean frame 0,1,0,0,0,0,0,0,1,1 with no residue from 0x55.

Source files
------------

// File: rtl/serial_byte_tx_if.sv
// Byte-stream handshake feeding the serial transmitter.
interface serial_byte_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;

  modport master (output in_valid, output in_byte, input in_ready);
  modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/serial_byte_tx.sv
// Frames each accepted byte as start, 8 data bits LSB first, optional parity and
// STOP_BITS stop bits, one bit per clock; the line idles high.
module serial_byte_tx #(
  parameter int PARITY    = 0,  // 0 none, 1 even, 2 odd
  parameter int STOP_BITS = 1   // 1 or 2
) (
  input  logic              clk,
  input  logic              reset,
  serial_byte_tx_if.slave   in_if,
  output logic              dout,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       dout_q, dout_d;
  logic       last_stop, accept;

  assign last_stop       = (state_q == STOP) && (cnt_q == STOP_LAST);
  // Gated by reset so nothing is taken while the block is held in reset.
  assign in_if.in_ready  = reset && ((state_q == IDLE) || last_stop);
  assign accept          = in_if.in_valid && in_if.in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    dout_d  = 1'b1;

    case (state_q)
      IDLE:  ;
      START: begin
        state_d = DATA;
        cnt_d   = 3'd0;
      end
      DATA: begin
        if (cnt_q == 3'd7) begin
          state_d = (PARITY != 0) ? PAR : STOP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          shift_d = shift_q >> 1;
        end
      end
      PAR: begin
        state_d = STOP;
        cnt_d   = 3'd0;
      end
      STOP: begin
        if (last_stop) state_d = IDLE;
        else           cnt_d   = cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase

    // An accept in the last stop cycle overrides the return to IDLE.
    if (accept) begin
      state_d = START;
      cnt_d   = 3'd0;
      shift_d = in_if.in_byte;
      par_d   = (^in_if.in_byte) ^ (PARITY == 2);
    end

    // dout is registered, so it is computed from the state being entered.
    case (state_d)
      IDLE:    dout_d = 1'b1;
      START:   dout_d = 1'b0;
      DATA:    dout_d = shift_d[0];
      PAR:     dout_d = par_d;
      STOP:    dout_d = 1'b1;
      default: dout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_byte_tx.sv
// Four transmitter configurations checked against a frame-list reference model.
module tb_serial_byte_tx;
  localparam int ND = 4;  // d0 default, d1 even parity, d2 odd parity, d3 two stop bits

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [ND-1:0]         vld = '0;
  logic [ND-1:0][7:0]    byt = '0;
  wire  [ND-1:0]         rdy, dout, busy;

  logic [15:0]           fr [ND];
  int                    rem [ND];
  logic [ND-1:0]         acc, exp_dout, exp_busy, exp_rdy;
  int                    checks = 0;
  int                    errors = 0;

  always #5 clk = ~clk;

  serial_byte_tx_if if0 ();
  serial_byte_tx_if if1 ();
  serial_byte_tx_if if2 ();
  serial_byte_tx_if if3 ();

  assign if0.in_valid = vld[0]; assign if0.in_byte = byt[0]; assign rdy[0] = if0.in_ready;
  assign if1.in_valid = vld[1]; assign if1.in_byte = byt[1]; assign rdy[1] = if1.in_ready;
  assign if2.in_valid = vld[2]; assign if2.in_byte = byt[2]; assign rdy[2] = if2.in_ready;
  assign if3.in_valid = vld[3]; assign if3.in_byte = byt[3]; assign rdy[3] = if3.in_ready;

  serial_byte_tx #(.PARITY(0), .STOP_BITS(1)) u_d0 (.clk(clk), .reset(reset), .in_if(if0), .dout(dout[0]), .busy(busy[0]));
  serial_byte_tx #(.PARITY(1), .STOP_BITS(1)) u_d1 (.clk(clk), .reset(reset), .in_if(if1), .dout(dout[1]), .busy(busy[1]));
  serial_byte_tx #(.PARITY(2), .STOP_BITS(1)) u_d2 (.clk(clk), .reset(reset), .in_if(if2), .dout(dout[2]), .busy(busy[2]));
  serial_byte_tx #(.PARITY(0), .STOP_BITS(2)) u_d3 (.clk(clk), .reset(reset), .in_if(if3), .dout(dout[3]), .busy(busy[3]));

  function automatic int par_of(int d);
    return (d == 1) ? 1 : (d == 2) ? 2 : 0;
  endfunction

  function automatic int stops_of(int d);
    return (d == 3) ? 2 : 1;
  endfunction

  function automatic int flen(int d);
    return 9 + ((par_of(d) != 0) ? 1 : 0) + stops_of(d);
  endfunction

  // Line bits of one frame, element 0 first; unused upper bits are stop/idle ones.
  function automatic logic [15:0] frame(int d, logic [7:0] b);
    logic [15:0] f;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = b[k];
    ones = $countones(b);
    if (par_of(d) == 1) f[9] = (ones % 2 == 1);
    if (par_of(d) == 2) f[9] = (ones % 2 == 0);
    return f;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      rem[d] = 0; fr[d] = '1;
      exp_dout[d] = 1'b1; exp_busy[d] = 1'b0; exp_rdy[d] = 1'b0;
    end
  endfunction

  // One clock: decide model acceptance before the edge, then advance the line model.
  task automatic tick();
    for (int d = 0; d < ND; d++) acc[d] = reset && vld[d] && (rem[d] == 0);
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      if (!reset) rem[d] = 0;
      else if (acc[d]) begin fr[d] = frame(d, byt[d]); rem[d] = flen(d); end
      if (rem[d] > 0) begin
        exp_dout[d] = fr[d][0]; fr[d] = fr[d] >> 1; rem[d]--; exp_busy[d] = 1'b1;
      end else begin
        exp_dout[d] = 1'b1; exp_busy[d] = 1'b0;
      end
      exp_rdy[d] = reset && (rem[d] == 0);
    end
  endtask

  task automatic send(int d, logic [7:0] b);
    vld[d] = 1'b1; byt[d] = b;
    for (int t = 0; t < 64; t++) begin tick(); if (acc[d]) break; end
    vld[d] = 1'b0;
    checks++;
    if (!acc[d]) begin errors++; $display("FAIL send_timeout d%0d got no accept want accept", d); end
  endtask

  task automatic test_reset();
    reset = 1'b0; vld = '1;
    for (int d = 0; d < ND; d++) byt[d] = 8'($urandom);
    repeat (3) begin
      tick();
      for (int d = 0; d < ND; d++) begin
        checks++; if (dout[d] !== 1'b1) begin errors++; $display("FAIL reset_dout d%0d got %b want 1", d, dout[d]); end
        checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d%0d got %b want 0", d, busy[d]); end
      end
    end
    reset = 1'b1; vld = '0;
    repeat (20) begin
      tick();
      for (int d = 0; d < ND; d++) begin
        checks++; if (dout[d] !== 1'b1) begin errors++; $display("FAIL idle_dout d%0d got %b want 1", d, dout[d]); end
        checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL idle_busy d%0d got %b want 0", d, busy[d]); end
        checks++; if (rdy[d] !== 1'b1) begin errors++; $display("FAIL idle_ready d%0d got %b want 1", d, rdy[d]); end
      end
    end
  endtask

  task automatic test_single();
    int exp_seq [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    logic [7:0] rx;
    rx = '0;
    send(0, 8'hA5);
    for (int i = 0; i < 11; i++) begin
      checks++; if (dout[0] !== exp_seq[i][0]) begin errors++; $display("FAIL single_dout i%0d got %b want %0d", i, dout[0], exp_seq[i]); end
      checks++; if (rdy[0] !== (i >= 9)) begin errors++; $display("FAIL single_ready i%0d got %b want %b", i, rdy[0], (i >= 9)); end
      if (i >= 1 && i <= 8) rx[i-1] = dout[0];
      tick();
    end
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL single_rx got %h want a5", rx); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] got, gbusy;
    int acc_at;
    localparam logic [19:0] EXP = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    acc_at = -1; got = '0; gbusy = '0;
    vld[0] = 1'b1; byt[0] = 8'h00;
    for (int t = 0; t < 64; t++) begin tick(); if (acc[0]) break; end
    byt[0] = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      got[i] = dout[0]; gbusy[i] = busy[0];
      tick();
      if (acc[0] && vld[0]) begin acc_at = i; vld[0] = 1'b0; end
    end
    vld[0] = 1'b0;
    checks++; if (got !== EXP) begin errors++; $display("FAIL b2b_line got %b want %b", got, EXP); end
    checks++; if (gbusy !== '1) begin errors++; $display("FAIL b2b_busy got %b want all ones", gbusy); end
    checks++; if (acc_at != 9) begin errors++; $display("FAIL b2b_accept_cycle got %0d want 9", acc_at); end
    repeat (3) tick();
  endtask

  task automatic test_parity();
    vld[1] = 1'b1; vld[2] = 1'b1; byt[1] = 8'h07; byt[2] = 8'h07;
    tick();
    vld[1] = 1'b0; vld[2] = 1'b0;
    checks++; if (!(acc[1] && acc[2])) begin errors++; $display("FAIL par_accept got %b%b want 11", acc[1], acc[2]); end
    for (int i = 0; i < 12; i++) begin
      if (i == 9) begin
        checks++; if (dout[1] !== 1'b1) begin errors++; $display("FAIL par_even got %b want 1", dout[1]); end
        checks++; if (dout[2] !== 1'b0) begin errors++; $display("FAIL par_odd got %b want 0", dout[2]); end
        checks++; if (rdy[2:1] !== 2'b00) begin errors++; $display("FAIL par_ready_pbit got %b want 00", rdy[2:1]); end
      end
      if (i == 10) begin
        checks++; if (dout[2:1] !== 2'b11) begin errors++; $display("FAIL par_stop got %b want 11", dout[2:1]); end
        checks++; if (busy[2:1] !== 2'b11) begin errors++; $display("FAIL par_busy_stop got %b want 11", busy[2:1]); end
        checks++; if (rdy[2:1] !== 2'b11) begin errors++; $display("FAIL par_ready_stop got %b want 11", rdy[2:1]); end
      end
      if (i == 11) begin
        checks++; if (busy[2:1] !== 2'b00) begin errors++; $display("FAIL par_busy_idle got %b want 00", busy[2:1]); end
      end
      tick();
    end
  endtask

  task automatic test_two_stop();
    logic [23:0] got, grdy;
    int acc_at;
    localparam logic [23:0] EXP_LINE = {2'b11, 2'b11, 8'hC3, 1'b0, 2'b11, 8'h3C, 1'b0};
    localparam logic [23:0] EXP_RDY  = 24'hE00400;
    acc_at = -1; got = '0; grdy = '0;
    vld[3] = 1'b1; byt[3] = 8'h3C;
    for (int t = 0; t < 64; t++) begin tick(); if (acc[3]) break; end
    byt[3] = 8'hC3;
    for (int i = 0; i < 24; i++) begin
      got[i] = dout[3]; grdy[i] = rdy[3];
      tick();
      if (acc[3] && vld[3]) begin acc_at = i; vld[3] = 1'b0; end
    end
    vld[3] = 1'b0;
    checks++; if (got !== EXP_LINE) begin errors++; $display("FAIL stop2_line got %b want %b", got, EXP_LINE); end
    checks++; if (grdy !== EXP_RDY) begin errors++; $display("FAIL stop2_ready got %b want %b", grdy, EXP_RDY); end
    checks++; if (acc_at != 10) begin errors++; $display("FAIL stop2_accept_cycle got %0d want 10", acc_at); end
  endtask

  task automatic test_mid_reset();
    int exp_seq [11] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    send(0, 8'h55);
    repeat (4) tick();
    checks++; if ({busy[0], dout[0]} !== 2'b10) begin errors++; $display("FAIL midrst_before got busy=%b dout=%b want busy=1 dout=0", busy[0], dout[0]); end
    reset = 1'b0; #1;
    model_reset();
    checks++; if (dout[0] !== 1'b1) begin errors++; $display("FAIL midrst_dout got %b want 1", dout[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy[0]); end
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (dout[0] !== 1'b1) begin errors++; $display("FAIL midrst_idle got %b want 1", dout[0]); end
    send(0, 8'h81);
    for (int i = 0; i < 11; i++) begin
      checks++; if (dout[0] !== exp_seq[i][0]) begin errors++; $display("FAIL midrst_frame i%0d got %b want %0d", i, dout[0], exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_random();
    int frames = 0;
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < ND; d++)
        if (!vld[d] && $urandom_range(0, 3) != 0) begin vld[d] = 1'b1; byt[d] = 8'($urandom); end
      tick();
      for (int d = 0; d < ND; d++) begin
        if (acc[d]) begin vld[d] = 1'b0; frames++; end
        checks++; if (dout[d] !== exp_dout[d]) begin errors++; $display("FAIL rand_dout c%0d d%0d got %b want %b", c, d, dout[d], exp_dout[d]); end
        checks++; if (busy[d] !== exp_busy[d]) begin errors++; $display("FAIL rand_busy c%0d d%0d got %b want %b", c, d, busy[d], exp_busy[d]); end
        checks++; if (rdy[d] !== exp_rdy[d]) begin errors++; $display("FAIL rand_ready c%0d d%0d got %b want %b", c, d, rdy[d], exp_rdy[d]); end
      end
    end
    vld = '0;
    checks++; if (frames < 40) begin errors++; $display("FAIL rand_frames got %0d want >= 40", frames); end
    repeat (15) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
